// File: rtl/mult_pipe_bp.sv
// Pipelined DW x DW multiplier (signed/unsigned, low/high half) carrying an htId sideband.
// A credit counter admits inputs only while an output FIFO slot is reserved, so the pipeline never stalls.
module mult_pipe_bp #(
    parameter int DW     = 64,
    parameter int HTID_W = 9,
    parameter int LAT    = 18,
    parameter int DEPTH  = 32
) (
    input  logic                         ck,
    input  logic                         i_reset_n,
    input  logic                         i_vld,
    output logic                         o_rdy,
    input  logic [DW-1:0]                i_a,
    input  logic [DW-1:0]                i_b,
    input  logic                         i_signed,
    input  logic                         i_hi,
    input  logic [HTID_W-1:0]            i_htId,
    output logic                         o_vld,
    input  logic                         i_rdy,
    output logic [DW-1:0]                o_res,
    output logic [HTID_W-1:0]            o_htId,
    output logic [$clog2(DEPTH+1)-1:0]   o_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Handshake: input transfers when i_vld && o_rdy; output pops when o_vld && i_rdy.
    // o_rdy depends only on registered credits, never on the same-cycle pop.
    logic              w_acc;
    logic              w_pop;
    logic              w_wr;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_fcnt;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;

    logic [DW-1:0]     r_s1_a;
    logic [DW-1:0]     r_s1_b;
    logic              r_s1_sgn;
    logic              r_s1_hi;
    logic [LAT-1:0]    r_vld_sr;
    logic [HTID_W-1:0] r_ht_sr  [LAT];
    logic [DW-1:0]     r_res_sr [1:LAT-1];

    logic [2*DW-1:0]   w_a_ext;
    logic [2*DW-1:0]   w_b_ext;
    logic [2*DW-1:0]   w_prod;
    logic [DW-1:0]     w_sel;

    logic [DW-1:0]     r_mem_res [DEPTH];
    logic [HTID_W-1:0] r_mem_ht  [DEPTH];

    assign o_rdy = (r_cnt < CW'(DEPTH));
    assign o_vld = (r_fcnt != '0);
    assign w_acc = i_vld && o_rdy;
    assign w_pop = o_vld && i_rdy;
    assign w_wr  = r_vld_sr[LAT-1];

    // Mode handled by extension width: the low 2DW bits of the product are correct either way.
    assign w_a_ext = {{DW{r_s1_sgn & r_s1_a[DW-1]}}, r_s1_a};
    assign w_b_ext = {{DW{r_s1_sgn & r_s1_b[DW-1]}}, r_s1_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_sel   = r_s1_hi ? w_prod[2*DW-1:DW] : w_prod[DW-1:0];

    always_ff @(posedge ck) begin
        if (w_acc) begin
            r_s1_a   <= i_a;
            r_s1_b   <= i_b;
            r_s1_sgn <= i_signed;
            r_s1_hi  <= i_hi;
        end
    end

    // Data path is unreset; the valid shift register alone decides what reaches the FIFO.
    always_ff @(posedge ck) begin
        r_ht_sr[0]  <= i_htId;
        r_res_sr[1] <= w_sel;
        for (int k = 1; k < LAT; k++) begin
            r_ht_sr[k] <= r_ht_sr[k-1];
        end
        for (int k = 2; k < LAT; k++) begin
            r_res_sr[k] <= r_res_sr[k-1];
        end
        if (w_wr) begin
            r_mem_res[r_wr_ptr] <= r_res_sr[LAT-1];
            r_mem_ht[r_wr_ptr]  <= r_ht_sr[LAT-1];
        end
    end

    always_ff @(posedge ck or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vld_sr <= '0;
            r_cnt    <= '0;
            r_fcnt   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (LAT > 1) begin
                r_vld_sr <= {r_vld_sr[LAT-2:0], w_acc};
            end
            if (w_acc && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_acc && w_pop) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CW'(1);
                2'b01:   r_fcnt <= r_fcnt - CW'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    assign o_res  = r_mem_res[r_rd_ptr];
    assign o_htId = r_mem_ht[r_rd_ptr];
    assign o_cnt  = r_cnt;

endmodule

// File: tb/tb_mult_pipe_bp.sv
// Bench for mult_pipe_bp: vector table plus scripted corner cases, results checked against
// an in-order expected queue filled at input acceptance.
module tb_mult_pipe_bp;
    localparam int DW     = 64;
    localparam int HTID_W = 9;
    localparam int LAT    = 18;
    localparam int DEPTH  = 32;
    localparam int CW     = $clog2(DEPTH+1);
    localparam int W      = HTID_W + DW;

    typedef struct {
        logic [DW-1:0]     a;
        logic [DW-1:0]     b;
        logic              sgn;
        logic              hi;
        logic [HTID_W-1:0] ht;
        logic [DW-1:0]     exp;
    } vec_t;

    logic              ck = 1'b0;
    logic              i_reset_n = 1'b0;
    logic              i_vld = 1'b0;
    logic              o_rdy;
    logic [DW-1:0]     i_a = '0;
    logic [DW-1:0]     i_b = '0;
    logic              i_signed = 1'b0;
    logic              i_hi = 1'b0;
    logic [HTID_W-1:0] i_htId = '0;
    logic              o_vld;
    logic              i_rdy = 1'b1;
    logic [DW-1:0]     o_res;
    logic [HTID_W-1:0] o_htId;
    logic [CW-1:0]     o_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [W-1:0] exp_q[$];
    int pop_cyc_q[$];
    vec_t tbl[9];

    mult_pipe_bp #(.DW(DW), .HTID_W(HTID_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .ck(ck), .i_reset_n(i_reset_n), .i_vld(i_vld), .o_rdy(o_rdy),
        .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .i_hi(i_hi), .i_htId(i_htId),
        .o_vld(o_vld), .i_rdy(i_rdy), .o_res(o_res), .o_htId(o_htId), .o_cnt(o_cnt)
    );

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic sgn, input logic hi);
        logic signed [2*DW-1:0] sa, sb, sp;
        logic [2*DW-1:0] p;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            sp = sa * sb;
            p  = sp;
        end else begin
            p = {{DW{1'b0}}, a};
            p = p * {{DW{1'b0}}, b};
        end
        return hi ? p[2*DW-1:DW] : p[DW-1:0];
    endfunction

    // Output monitor: credit bound every cycle, scoreboard compare on every pop.
    always @(negedge ck) begin
        if (i_reset_n) begin
            check("cnt_bound", 128'(o_cnt <= CW'(DEPTH)), 128'd1);
            if (o_vld && i_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got ht=%0h res=%0h, required no output", o_htId, o_res);
                end else begin
                    check("result", {o_htId, o_res}, exp_q.pop_front());
                end
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic drive_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sgn,
                            input logic hi, input logic [HTID_W-1:0] ht, input logic [DW-1:0] exp);
        int waited = 0;
        i_vld = 1'b1; i_a = a; i_b = b; i_signed = sgn; i_hi = hi; i_htId = ht;
        forever begin
            @(negedge ck);
            if (o_rdy) begin
                exp_q.push_back({ht, exp});
                break;
            end
            waited++;
            if (waited > 5000) begin
                check("accept_timeout", 128'd0, 128'd1);
                break;
            end
        end
        @(posedge ck); #1;
        i_vld = 1'b0;
    endtask

    task automatic drive_rand(input logic [HTID_W-1:0] ht);
        logic [DW-1:0] a, b;
        logic sgn, hi;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        sgn = 1'($urandom_range(0, 1)); hi = 1'($urandom_range(0, 1));
        drive_op(a, b, sgn, hi, ht, model(a, b, sgn, hi));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge ck);
            n++;
        end
        check({name, "_drained"}, 128'(exp_q.size()), 128'd0);
        @(posedge ck); #1;
        check({name, "_cnt_zero"}, 128'(o_cnt), 128'd0);
    endtask

    task automatic do_reset(input int cycles);
        i_reset_n = 1'b0;
        i_vld = 1'b0;
        repeat (cycles) @(posedge ck);
        #1 i_reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic run_single(input vec_t v, input string name);
        int start, n;
        i_rdy = 1'b1;
        drive_op(v.a, v.b, v.sgn, v.hi, v.ht, v.exp);
        start = cyc;
        n = 0;
        do begin
            @(negedge ck);
            n++;
        end while (!o_vld && n < 200);
        check({name, "_latency"}, 128'(cyc - start), 128'(LAT));
        wait_drain(name, 200);
    endtask

    task automatic run_burst(input int first, input int last, input string name);
        pop_cyc_q.delete();
        i_rdy = 1'b1;
        for (int i = first; i <= last; i++) begin
            drive_op(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].hi, tbl[i].ht, tbl[i].exp);
        end
        wait_drain(name, 200);
        check({name, "_count"}, 128'(pop_cyc_q.size()), 128'(last - first + 1));
        for (int i = 1; i < pop_cyc_q.size(); i++) begin
            check({name, "_consecutive"}, 128'(pop_cyc_q[i] - pop_cyc_q[i-1]), 128'd1);
        end
    endtask

    initial begin
        tbl[0] = '{64'd3, 64'd5, 1'b0, 1'b0, 9'h1A5, 64'd15};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b1, 9'h001, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 9'h002, 64'hFFFF_FFFF_FFFF_FFFE};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b1, 9'h003, 64'd1};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 9'h004, 64'hFFFF_FFFF_FFFF_FFFE};
        tbl[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 9'h0A5, 64'h4000_0000_0000_0000};
        tbl[6] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 9'h0A6, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b0, 9'h0A7, 64'hFFFF_FFFF_FFFF_FFF1};
        tbl[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 9'h0A8, 64'hFFFF_FFFF_FFFF_FFFE};

        // Reset and idle
        do_reset(3);
        check("reset_o_vld", 128'(o_vld), 128'd0);
        check("reset_o_rdy", 128'(o_rdy), 128'd1);
        check("reset_o_cnt", 128'(o_cnt), 128'd0);
        repeat (100) begin
            @(negedge ck);
            check("idle_o_vld", 128'(o_vld), 128'd0);
        end
        @(posedge ck); #1;

        // Single unsigned op with exact latency, then table bursts
        run_single(tbl[0], "single");
        run_burst(1, 4, "mode_matrix");
        run_burst(5, 8, "corner_burst");

        // Backpressure fill: exactly DEPTH accepts, then drain in order
        i_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) drive_rand(HTID_W'(i));
        check("fill_o_rdy", 128'(o_rdy), 128'd0);
        check("fill_o_cnt", 128'(o_cnt), 128'(DEPTH));
        i_vld = 1'b1; i_htId = '1;
        repeat (30) begin
            @(negedge ck);
            check("full_no_accept", 128'(o_rdy), 128'd0);
        end
        @(posedge ck); #1;
        i_vld = 1'b0;
        check("full_o_vld", 128'(o_vld), 128'd1);
        i_rdy = 1'b1;
        @(negedge ck);
        check("rdy_low_during_first_pop", 128'(o_rdy), 128'd0);
        @(negedge ck);
        check("rdy_after_first_pop", 128'(o_rdy), 128'd1);
        check("cnt_after_first_pop", 128'(o_cnt), 128'(DEPTH - 1));
        wait_drain("fill_drain", 200);

        // Steady state around full with random consumer
        i_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) drive_rand(HTID_W'(i));
        for (int c = 0; c < 1000; c++) begin
            logic [DW-1:0] a, b;
            logic sgn, hi;
            logic [HTID_W-1:0] ht;
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            sgn = 1'($urandom_range(0, 1)); hi = 1'($urandom_range(0, 1));
            ht = HTID_W'($urandom_range(0, (1 << HTID_W) - 1));
            i_rdy = 1'($urandom_range(0, 1));
            i_vld = 1'b1; i_a = a; i_b = b; i_signed = sgn; i_hi = hi; i_htId = ht;
            @(negedge ck);
            if (o_rdy) exp_q.push_back({ht, model(a, b, sgn, hi)});
            @(posedge ck); #1;
        end
        i_vld = 1'b0;
        i_rdy = 1'b1;
        wait_drain("steady", 400);

        // Reset mid-stream discards everything
        i_rdy = 1'b0;
        for (int i = 0; i < 10; i++) drive_rand(HTID_W'(9'h100 + i));
        repeat (LAT - 4) @(posedge ck);
        #1;
        check("pre_reset_o_vld", 128'(o_vld), 128'd1);
        i_reset_n = 1'b0;
        #1;
        check("midreset_o_vld", 128'(o_vld), 128'd0);
        check("midreset_o_rdy", 128'(o_rdy), 128'd1);
        check("midreset_o_cnt", 128'(o_cnt), 128'd0);
        @(posedge ck); #1;
        i_reset_n = 1'b1;
        exp_q.delete();
        i_rdy = 1'b1;
        repeat (LAT + 10) begin
            @(negedge ck);
            check("no_stale_after_reset", 128'(o_vld), 128'd0);
        end
        @(posedge ck); #1;
        run_single(tbl[7], "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

endmodule
